alu_op_sequencer: RTL and testbench

Sequencer that feeds the 8-bit ALU from a single operand stream. It captures operand A, then operand B with the opcode, and holds both stable at the ALU inputs for a configurable settle time. It then registers the ALU result and flags and presents them on a valid/ready output handshake. It sits between the board input logic (switches/UART front end) and the ALU, and owns all operand, result and flag registers.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_op_sequencer_operand_reg.sv | 27 ++
 rtl/alu_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned FLAG_N   = 3;
  localparam int unsigned FLAG_Z   = 2;
  localparam int unsigned FLAG_C   = 1;
  localparam int unsigned FLAG_V   = 0;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned OPCNT_W  = 8;

endpackage

// File: rtl/alu_op_sequencer_operand_reg.sv
// Load-enabled DATA_W-wide register used for operand A, operand B and the result.
module operand_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) data_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Captures A, then B+opcode, holds them at the ALU for EXEC_CYCLES, then offers the result.
// Optional accumulator chaining is enabled with ALU_SEQ_CHAIN_EN.
module alu_op_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OP_W        = 3,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OP_W-1:0]   in_op,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic              in_chain,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        res_flags,
  output logic              busy,
  output logic [7:0]        op_count
);

  import alu_seq_pkg::*;

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                res_valid_q, res_valid_d;
  logic [OPCNT_W-1:0]  op_count_q, op_count_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                load_a, load_b, load_res;
  logic [DATA_W-1:0]   a_src;
  logic                in_hs;

  assign in_ready = ((state_q == GET_A) || (state_q == GET_B)) && !reset;
  assign in_hs    = in_valid && in_ready;

  // Next state and register-load decisions; abort overrides any handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;
    op_d        = op_q;
    flags_d     = flags_q;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_res    = 1'b0;
    a_src       = in_data;
    if (abort) begin
      state_d     = GET_A;
      res_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        GET_A: begin
          if (in_hs) begin
            load_a  = 1'b1;
            state_d = GET_B;
          end
        end
        GET_B: begin
          if (in_hs) begin
            load_b  = 1'b1;
            op_d    = in_op;
            cnt_d   = CNT_W'(EXEC_CYCLES - 1);
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            load_res    = 1'b1;
            flags_d     = alu_flags;
            res_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            op_count_d  = op_count_q + OPCNT_W'(1);
            state_d     = GET_A;
`ifdef ALU_SEQ_CHAIN_EN
            // Accumulator chaining: the accepted result becomes the next operand A.
            if (in_chain) begin
              load_a  = 1'b1;
              a_src   = res_data;
              state_d = GET_B;
            end
`endif
          end
        end
        default: state_d = GET_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= GET_A;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
      op_q        <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
      op_q        <= op_d;
      flags_q     <= flags_d;
    end
  end

  operand_reg #(.DATA_W(DATA_W)) u_reg_a (
    .clk(clk), .reset(reset), .load(load_a), .d(a_src), .q(alu_a)
  );

  operand_reg #(.DATA_W(DATA_W)) u_reg_b (
    .clk(clk), .reset(reset), .load(load_b), .d(in_data), .q(alu_b)
  );

  operand_reg #(.DATA_W(DATA_W)) u_reg_res (
    .clk(clk), .reset(reset), .load(load_res), .d(alu_result), .q(res_data)
  );

  assign alu_op    = op_q;
  assign res_flags = flags_q;
  assign res_valid = res_valid_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q == EXEC) || (state_q == HOLD);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table, corner-case sequences, random ops.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned EC = 3;

  logic       clk = 1'b0;
  logic       reset, abort, in_valid, in_ready, res_valid, res_ready, busy;
  logic [7:0] in_data, alu_a, alu_b, alu_result, res_data, op_count;
  logic [2:0] in_op, alu_op;
  logic [3:0] alu_flags, res_flags;
  logic       in_chain;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_cnt;
  logic [2:0] exp_op;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(8), .OP_W(3), .EXEC_CYCLES(EC)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
`ifdef ALU_SEQ_CHAIN_EN
    .in_chain(in_chain),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .busy(busy), .op_count(op_count)
  );

  // Reference ALU: {flags, result}; ADD for 000, SUB (C = borrow) for 001, XOR otherwise.
  function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    int         s;
    logic [7:0] r;
    logic [3:0] f;
    f = '0;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b);
        r = 8'(s);
        f[FLAG_C] = (s > 255);
        f[FLAG_V] = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        s = int'(a) - int'(b);
        r = 8'(s);
        f[FLAG_C] = (s < 0);
        f[FLAG_V] = (a[7] != b[7]) && (r[7] != a[7]);
      end
      default: r = a ^ b;
    endcase
    f[FLAG_N] = r[7];
    f[FLAG_Z] = (r == 8'h00);
    return {f, r};
  endfunction

  always_comb {alu_flags, alu_result} = ref_alu(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = 1'b1; in_data = a; in_op = ~op;
    chk("in_ready A", 32'(in_ready), 32'd1);
    step();
    chk("alu_a load", 32'(alu_a), 32'(a));
    chk("alu_op held at A", 32'(alu_op), 32'(exp_op));
    in_data = b; in_op = op;
    chk("in_ready B", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    exp_op   = op;
    chk("alu_b load", 32'(alu_b), 32'(b));
    chk("alu_op load", 32'(alu_op), 32'(op));
    chk("busy exec", 32'(busy), 32'd1);
    chk("in_ready exec", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_res();
    int w = 0;
    while (!res_valid && w < 40) begin
      step();
      w++;
    end
    chk("result latency", 32'(w), 32'(EC));
  endtask

  // Backpressure for bp cycles with in_valid held high, then accept.
  task automatic accept(input int bp, input logic [7:0] a, input logic [7:0] want_res,
                        input logic [3:0] want_flags);
    chk("res_data", 32'(res_data), 32'(want_res));
    chk("res_flags", 32'(res_flags), 32'(want_flags));
    in_valid = 1'b1; in_data = ~a; res_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      step();
      chk("bp res_valid", 32'(res_valid), 32'd1);
      chk("bp res_data stable", 32'(res_data), 32'(want_res));
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_cnt   = exp_cnt + 8'd1;
    chk("A not loaded during HOLD", 32'(alu_a), 32'(a));
    in_valid = 1'b0;
    chk("res_valid cleared", 32'(res_valid), 32'd0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
    chk("busy idle", 32'(busy), 32'd0);
    chk("in_ready idle", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input int bp, input logic [11:0] want);
    load_ab(a, b, op);
    wait_res();
    accept(bp, a, want[7:0], want[11:8]);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    int         bp;
    logic [7:0] res;
    logic [3:0] flags;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'h12, 8'h34, 3'd0, 0, 8'h46, 4'b0000};
    tbl[1] = '{8'hFF, 8'h01, 3'd0, 1, 8'h00, 4'b0110};
    tbl[2] = '{8'h05, 8'h03, 3'd1, 5, 8'h02, 4'b0000};
    tbl[3] = '{8'h03, 8'h05, 3'd1, 2, 8'hFE, 4'b1010};
    tbl[4] = '{8'h7F, 8'h01, 3'd0, 0, 8'h80, 4'b1001};
    tbl[5] = '{8'h80, 8'h01, 3'd1, 3, 8'h7F, 4'b0001};

    reset = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0;
    res_ready = 1'b0; in_chain = 1'b0;
    exp_cnt = '0; exp_op = '0;

    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset regs", {alu_a, alu_b, res_data, op_count}, 32'd0);
    chk("reset ctrl", {alu_op, res_flags, res_valid, busy}, 32'd0);
    reset = 1'b0;
    #1;
    chk("in_ready after reset", 32'(in_ready), 32'd1);
    @(negedge clk);

    foreach (tbl[i])
      do_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].bp, {tbl[i].flags, tbl[i].res});

    // Abort during EXEC: no result, operands and count retained.
    load_ab(8'h21, 8'h0F, 3'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < EC + 2; i++) begin
      chk("abort res_valid", 32'(res_valid), 32'd0);
      step();
    end
    chk("abort op_count", 32'(op_count), 32'(exp_cnt));
    chk("abort keeps operands", {alu_a, alu_b}, {16'h0, 8'h21, 8'h0F});

    // Abort in GET_A with a valid beat: the beat is discarded.
    in_valid = 1'b1; in_data = 8'h99; abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort discards A", 32'(alu_a), 32'h21);

    // Abort in HOLD together with acceptance: no count increment.
    load_ab(8'h10, 8'h20, 3'd0);
    wait_res();
    res_ready = 1'b1; abort = 1'b1;
    step();
    res_ready = 1'b0; abort = 1'b0;
    chk("abort hold res_valid", 32'(res_valid), 32'd0);
    chk("abort hold op_count", 32'(op_count), 32'(exp_cnt));
    chk("abort hold busy", 32'(busy), 32'd0);

    // Asynchronous reset during HOLD.
    load_ab(8'h44, 8'h11, 3'd0);
    wait_res();
    reset = 1'b1;
    #1;
    chk("async reset regs", {alu_a, alu_b, res_data, op_count}, 32'd0);
    chk("async reset ctrl", {alu_op, res_flags, res_valid, busy, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0; exp_op = '0;
    #1;
    chk("in_ready after mid reset", 32'(in_ready), 32'd1);
    @(negedge clk);

`ifdef ALU_SEQ_CHAIN_EN
    load_ab(8'h05, 8'h03, 3'd0);
    wait_res();
    chk("chain first res", 32'(res_data), 32'h08);
    res_ready = 1'b1; in_chain = 1'b1;
    step();
    res_ready = 1'b0; in_chain = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("chain alu_a", 32'(alu_a), 32'h08);
    in_valid = 1'b1; in_data = 8'h02; in_op = 3'd1;
    step();
    in_valid = 1'b0; exp_op = 3'd1;
    wait_res();
    accept(0, 8'h08, 8'h06, 4'b0000);
    chk("chain op_count", 32'(op_count), 32'd2);
`endif

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra, rb;
      logic [2:0] rop;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 3'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) step();
      do_op(ra, rb, rop, int'($urandom_range(0, 3)), ref_alu(ra, rb, rop));
    end

    // Drive op_count to 255, then one more op must wrap to 0.
    while (exp_cnt != 8'd255) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ra, rb, 3'd0, 0, ref_alu(ra, rb, 3'd0));
    end
    do_op(8'h01, 8'h01, 3'd0, 0, {4'b0000, 8'h02});
    chk("op_count wrap", 32'(op_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
